// File: rtl/ifetch_queue_pkg.sv
// Shared defaults and the buffered fetch-entry type for the instruction-fetch queue.
package ifetch_queue_pkg;

    localparam int          DEFAULT_XLEN     = 32;
    localparam int          DEFAULT_ILEN     = 32;
    localparam int          DEFAULT_PC_STEP  = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [DEFAULT_ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// Power-of-two synchronous FIFO with flush, occupancy count and full/empty flags.
// The caller never pushes when full unless it pops in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: pipelined req/gnt fetch, in-order responses of any latency,
// DEPTH-entry instruction FIFO to decode, and redirect flush with old-path response dropping.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int               XLEN     = DEFAULT_XLEN,
    parameter int               ILEN     = DEFAULT_ILEN,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int               PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          EW      = XLEN + ILEN;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic            stray_ok_q, stray_ok_d;

    // The tag FIFO occupancy is exactly the number of outstanding requests.
    logic [CW-1:0]   outstanding, data_count;
    logic            tag_full, tag_empty, data_full, data_empty;
    logic [XLEN-1:0] tag_head;
    logic [EW-1:0]   head_entry;
    logic [CW:0]     live;
    logic            accept, resp, keep_resp, pop;

    always_comb begin
        live       = {1'b0, data_count} + {1'b0, outstanding} - {1'b0, drop_cnt_q};
        // Old-path requests still hold tag slots after a redirect, so the tag FIFO also gates issue.
        imem_req   = rst && !redirect_valid && !tag_full && (live < DEPTH_W);
        accept     = imem_req && imem_gnt;
        resp       = imem_rvalid && !tag_empty;
        keep_resp  = resp && (drop_cnt_q == '0) && !redirect_valid;
        pop        = !data_empty && inst_ready && !redirect_valid;

        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        stray_ok_d = stray_ok_q && !accept;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            drop_cnt_d = outstanding - CW'(resp);
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            if (resp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
            stray_ok_q <= 1'b1;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
            stray_ok_q <= stray_ok_d;
        end
    end

    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (accept),
        .push_data (fetch_pc_q),
        .pop       (resp),
        .pop_data  (tag_head),
        .count     (outstanding),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_data_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (keep_resp),
        .push_data ({tag_head, imem_rdata}),
        .pop       (pop),
        .pop_data  (head_entry),
        .count     (data_count),
        .full      (data_full),
        .empty     (data_empty)
    );

    assign imem_addr  = fetch_pc_q;
    assign inst_valid = !data_empty;
    assign inst_pc    = inst_valid ? head_entry[EW-1:ILEN] : '0;
    assign inst_data  = inst_valid ? head_entry[ILEN-1:0]  : '0;

    // Stray responses are tolerated only between reset and the first accepted request (late pre-reset data).
    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst)
        imem_rvalid |-> (!tag_empty || stray_ok_q));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        keep_resp |-> (!data_full || pop));

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: queue-based memory and delivery model, every output checked each cycle.
module tb_ifetch_queue;
    import ifetch_queue_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int epoch   = 0;
    int lat_lo  = 1;
    int lat_hi  = 1;
    int n_dut_acc = 0;
    logic [31:0] fetch_pc_m = 32'h0;
    pend_t        pend[$];
    fetch_entry_t fifo_m[$];

    ifetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Entered at a falling edge: drive one cycle of stimulus, check outputs, advance the model.
    task automatic step(input bit gnt, input bit rdy, input bit redir, input logic [31:0] rpc,
                        input bit rv_en, input bit late);
        bit    rv, exp_req, exp_valid;
        int    live;
        pend_t p;
        rv = late || (rv_en && pend.size() != 0 && pend[0].due <= cyc);
        imem_gnt       = gnt;
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rvalid    = rv;
        imem_rdata     = late ? $urandom : (rv ? mem_word(pend[0].addr) : 32'h0);
        #1;
        live = fifo_m.size();
        foreach (pend[i]) if (pend[i].epoch == epoch) live++;
        exp_req = !redir && live < DEPTH && pend.size() < DEPTH;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, fetch_pc_m);
        if (imem_req && gnt) n_dut_acc++;
        exp_valid = fifo_m.size() != 0;
        check("inst_valid", 32'(inst_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("inst_pc", inst_pc, fifo_m[0].pc);
            check("inst_data", inst_data, fifo_m[0].inst);
        end
        if (exp_valid && rdy && !redir) void'(fifo_m.pop_front());
        if (rv && !late) begin
            p = pend.pop_front();
            if (p.epoch == epoch && !redir) fifo_m.push_back('{pc: p.addr, inst: mem_word(p.addr)});
        end
        if (redir) begin
            fifo_m.delete();
            epoch++;
            fetch_pc_m = {rpc[31:2], 2'b00};
        end
        if (exp_req && gnt) begin
            pend.push_back('{addr: fetch_pc_m, epoch: epoch, due: cyc + $urandom_range(lat_hi, lat_lo)});
            fetch_pc_m = fetch_pc_m + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic expect_first_pc(input string tag, input logic [31:0] pc);
        for (int i = 0; i < 20 && !inst_valid; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check(tag, inst_pc, pc);
    endtask

    task automatic run(input int n, input bit gnt, input bit rdy);
        for (int i = 0; i < n; i++) step(gnt, rdy, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        int acc0;
        #3;
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_inst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Streaming, 1-cycle latency
        lat_lo = 1; lat_hi = 1;
        run(20, 1'b1, 1'b1);

        // Decode stall: start empty, exactly DEPTH requests get in
        step(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
        acc0 = n_dut_acc;
        run(10, 1'b1, 1'b0);
        check("stall_accepts", 32'(n_dut_acc - acc0), 32'd4);
        run(12, 1'b1, 1'b1);

        // Toggling grant, latency 3
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 30; i++) step(i[0] == 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        // Redirect with requests in flight
        run(8, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0);
        expect_first_pc("redir_first_pc", 32'h100);
        run(6, 1'b1, 1'b1);

        // Redirect colliding with response and pop; unaligned target
        lat_lo = 1; lat_hi = 1;
        run(6, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h103, 1'b1, 1'b0);
        expect_first_pc("unaligned_first_pc", 32'h100);
        run(6, 1'b1, 1'b1);

        // Back-to-back redirects
        lat_lo = 2; lat_hi = 2;
        run(5, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h400, 1'b1, 1'b0);
        expect_first_pc("b2b_first_pc", 32'h400);
        run(6, 1'b1, 1'b1);

        // Address wrap
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0);
        run(8, 1'b1, 1'b1);

        // Reset mid-stream, then late responses after release
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 40 && pend.size() != 2; i++)
            step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_imem_req", 32'(imem_req), 32'h0);
        check("mid_rst_inst_valid", 32'(inst_valid), 32'h0);
        check("mid_rst_inst_data", inst_data, 32'h0);
        check("mid_rst_inst_pc", inst_pc, 32'h0);
        pend.delete();
        fifo_m.delete();
        epoch++;
        fetch_pc_m = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        expect_first_pc("post_rst_first_pc", 32'h0);
        run(6, 1'b1, 1'b1);

        // Random traffic with occasional redirects
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
                 $urandom & 32'h0000_FFFF, $urandom_range(0, 4) != 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
